// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage core: boot flush, memory freezes, load-use and redirect.
// Optional macro PIPE_HAZARD_PERF_EN adds saturating stall_cnt/flush_cnt outputs.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_LAT  = 2,
  parameter int unsigned BOOT_CYC = 2,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic             mem_access,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  output logic             en_pc,
  output logic             en_if_id,
  output logic             en_id_ex,
  output logic             en_ex_mem,
  output logic             en_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             flush_mem_wb,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
`ifdef PIPE_HAZARD_PERF_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic             busy
);

  localparam logic       LAT_EN   = (MEM_LAT != 0);
  localparam logic [3:0] LAT_M1   = (MEM_LAT == 0) ? 4'd0 : 4'(MEM_LAT - 1);
  localparam logic [3:0] BOOT_M1  = 4'(BOOT_CYC - 1);

  if (BOOT_CYC < 1 || BOOT_CYC > 15 || MEM_LAT > 15 || CNT_W < 1) begin : g_param_check
    $error("pipe_hazard_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {BOOT, RUN, WAIT} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       freeze, load_use, stall_inc, flush_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
      cnt   <= BOOT_M1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A freeze only starts from RUN; WAIT keeps it alive until cnt drains.
  always_comb begin
    freeze   = ((state == RUN) && mem_access && LAT_EN) || ((state == WAIT) && (cnt != 4'd0));
    load_use = ex_is_load && ex_regwrite && (ex_rd != 5'd0) &&
               ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    en_pc        = 1'b1;
    en_if_id     = 1'b1;
    en_id_ex     = 1'b1;
    en_ex_mem    = 1'b1;
    en_mem_wb    = 1'b1;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    flush_mem_wb = 1'b0;
    busy         = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    case (state)
      BOOT: begin
        {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb} = 5'b00000;
        {flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb} = 4'b1111;
        busy = 1'b1;
        if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
        else             state_nxt = RUN;
      end
      default: begin
        if (freeze) begin
          {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb} = 5'b00000;
          busy      = 1'b1;
          stall_inc = 1'b1;
          if (state == RUN) begin
            state_nxt = WAIT;
            cnt_nxt   = LAT_M1;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end else begin
          state_nxt = RUN;
          if (ex_redirect) begin
            // Redirect flushes ID anyway, so a coincident load-use needs no bubble.
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            flush_inc   = 1'b1;
          end else if (load_use) begin
            en_pc       = 1'b0;
            en_if_id    = 1'b0;
            flush_id_ex = 1'b1;
            stall_inc   = 1'b1;
          end
        end
      end
    endcase
  end

  // EX/MEM result is younger than MEM/WB, so it wins.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == ex_rs1))      fwd_a = 2'b01;
    else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == ex_rs1))    fwd_a = 2'b10;
    if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == ex_rs2))      fwd_b = 2'b01;
    else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == ex_rs2))    fwd_b = 2'b10;
  end

`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`else
  logic perf_unused;
  assign perf_unused = stall_inc ^ flush_inc;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: MEM_LAT=2 main instance plus a MEM_LAT=0 instance.
module tb_pipe_hazard_ctrl;

  localparam logic [8:0] BOOTV = 9'b00000_1111;
  localparam logic [8:0] RUNV  = 9'b11111_0000;
  localparam logic [8:0] FRZV  = 9'b00000_0000;
  localparam logic [8:0] LUV   = 9'b00111_0100;
  localparam logic [8:0] REDV  = 9'b11111_1100;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_uses_rs1, id_uses_rs2, ex_regwrite, ex_is_load, ex_redirect;
  logic mem_regwrite, mem_access, wb_regwrite;

  logic en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
  logic flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb, busy;
  logic [1:0] fwd_a, fwd_b;
  logic z_en_pc, z_en_if_id, z_en_id_ex, z_en_ex_mem, z_en_mem_wb;
  logic z_flush_if_id, z_flush_id_ex, z_flush_ex_mem, z_flush_mem_wb, z_busy;
  logic [1:0] z_fwd_a, z_fwd_b;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, z_stall_cnt, z_flush_cnt;
`endif

  logic [8:0] ctl, zctl;
  assign ctl  = {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
                 flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb};
  assign zctl = {z_en_pc, z_en_if_id, z_en_id_ex, z_en_ex_mem, z_en_mem_wb,
                 z_flush_if_id, z_flush_id_ex, z_flush_ex_mem, z_flush_mem_wb};

  int n_cmp = 0;
  int n_err = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_LAT(2), .BOOT_CYC(2), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_access(mem_access),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .en_pc(en_pc), .en_if_id(en_if_id), .en_id_ex(en_id_ex), .en_ex_mem(en_ex_mem),
    .en_mem_wb(en_mem_wb), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .flush_ex_mem(flush_ex_mem), .flush_mem_wb(flush_mem_wb),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
`ifdef PIPE_HAZARD_PERF_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .busy(busy)
  );

  pipe_hazard_ctrl #(.MEM_LAT(0), .BOOT_CYC(2), .CNT_W(32)) dut0 (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_access(mem_access),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .en_pc(z_en_pc), .en_if_id(z_en_if_id), .en_id_ex(z_en_id_ex), .en_ex_mem(z_en_ex_mem),
    .en_mem_wb(z_en_mem_wb), .flush_if_id(z_flush_if_id), .flush_id_ex(z_flush_id_ex),
    .flush_ex_mem(z_flush_ex_mem), .flush_mem_wb(z_flush_mem_wb),
    .fwd_a(z_fwd_a), .fwd_b(z_fwd_b),
`ifdef PIPE_HAZARD_PERF_EN
    .stall_cnt(z_stall_cnt), .flush_cnt(z_flush_cnt),
`endif
    .busy(z_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_uses_rs1, id_uses_rs2, ex_regwrite, ex_is_load, ex_redirect} = '0;
    {mem_regwrite, mem_access, wb_regwrite} = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    #12;
    n_cmp++; if (ctl !== BOOTV) begin n_err++; $display("FAIL reset_ctl: got %b want %b", ctl, BOOTV); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b want 1", busy); end
`ifdef PIPE_HAZARD_PERF_EN
    n_cmp++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      n_err++; $display("FAIL reset_perf: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
`endif
    @(negedge clk); reset = 1'b0; #1;
    n_cmp++; if (ctl !== BOOTV) begin n_err++; $display("FAIL boot_cyc1: got %b want %b", ctl, BOOTV); end
    step();
    n_cmp++; if (ctl !== BOOTV || busy !== 1'b1) begin
      n_err++; $display("FAIL boot_cyc2: got %b/%b want %b/1", ctl, busy, BOOTV); end
    step();
    n_cmp++; if (ctl !== RUNV || busy !== 1'b0) begin
      n_err++; $display("FAIL boot_cyc3_run: got %b/%b want %b/0", ctl, busy, RUNV); end
  endtask

  task automatic test_freeze();
    mem_access = 1'b1; #1;
    n_cmp++; if (ctl !== FRZV || busy !== 1'b1) begin
      n_err++; $display("FAIL freeze_c1: got %b/%b want %b/1", ctl, busy, FRZV); end
    n_cmp++; if (zctl !== RUNV || z_busy !== 1'b0) begin
      n_err++; $display("FAIL lat0_nofreeze: got %b/%b want %b/0", zctl, z_busy, RUNV); end
    step(); exp_stall++;
    n_cmp++; if (ctl !== FRZV || busy !== 1'b1) begin
      n_err++; $display("FAIL freeze_c2: got %b/%b want %b/1", ctl, busy, FRZV); end
    step(); exp_stall++;
    n_cmp++; if (ctl !== RUNV || busy !== 1'b0) begin
      n_err++; $display("FAIL freeze_c3_release: got %b/%b want %b/0", ctl, busy, RUNV); end
    step();
    mem_access = 1'b0; #1;
    n_cmp++; if (ctl !== RUNV) begin n_err++; $display("FAIL freeze_back_run: got %b want %b", ctl, RUNV); end
    // Back-to-back access gets a fresh freeze once RUN is reached again.
    mem_access = 1'b1; #1;
    n_cmp++; if (ctl !== FRZV) begin n_err++; $display("FAIL freeze_again: got %b want %b", ctl, FRZV); end
    step(); exp_stall++;
    step(); exp_stall++;
    mem_access = 1'b0;
    step();
  endtask

  task automatic test_load_use();
    ex_is_load = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1; #1;
    n_cmp++; if (ctl !== LUV) begin n_err++; $display("FAIL loaduse_rs2: got %b want %b", ctl, LUV); end
    step(); exp_stall++;
    id_uses_rs2 = 1'b0; #1;
    n_cmp++; if (ctl !== RUNV) begin n_err++; $display("FAIL loaduse_unused_rs2: got %b want %b", ctl, RUNV); end
    id_rs1 = 5'd5; id_uses_rs1 = 1'b1; #1;
    n_cmp++; if (ctl !== LUV) begin n_err++; $display("FAIL loaduse_rs1: got %b want %b", ctl, LUV); end
    step(); exp_stall++;
    ex_rd = 5'd0; id_rs1 = 5'd0; #1;
    n_cmp++; if (ctl !== RUNV) begin n_err++; $display("FAIL loaduse_rd0: got %b want %b", ctl, RUNV); end
    step();
  endtask

  task automatic test_redirect();
    ex_rd = 5'd5; id_rs1 = 5'd5; ex_redirect = 1'b1; #1;
    n_cmp++; if (ctl !== REDV) begin n_err++; $display("FAIL redirect_over_lu: got %b want %b", ctl, REDV); end
    step(); exp_flush++;
    clear_inputs();
    mem_access = 1'b1; ex_redirect = 1'b1; #1;
    n_cmp++; if (ctl !== FRZV) begin n_err++; $display("FAIL redirect_frozen1: got %b want %b", ctl, FRZV); end
    step(); exp_stall++;
    n_cmp++; if (ctl !== FRZV) begin n_err++; $display("FAIL redirect_frozen2: got %b want %b", ctl, FRZV); end
    step(); exp_stall++;
    n_cmp++; if (ctl !== REDV || busy !== 1'b0) begin
      n_err++; $display("FAIL redirect_after_freeze: got %b/%b want %b/0", ctl, busy, REDV); end
    step(); exp_flush++;
    clear_inputs(); #1;
`ifdef PIPE_HAZARD_PERF_EN
    n_cmp++; if (stall_cnt !== 32'(exp_stall)) begin
      n_err++; $display("FAIL perf_stall: got %0d want %0d", stall_cnt, exp_stall); end
    n_cmp++; if (flush_cnt !== 32'(exp_flush)) begin
      n_err++; $display("FAIL perf_flush: got %0d want %0d", flush_cnt, exp_flush); end
`endif
  endtask

  task automatic test_forward();
    ex_rs1 = 5'd7; ex_rs2 = 5'd9;
    mem_rd = 5'd7; mem_regwrite = 1'b1; wb_rd = 5'd7; wb_regwrite = 1'b1; #1;
    n_cmp++; if (fwd_a !== 2'b01) begin n_err++; $display("FAIL fwd_a_mem: got %b want 01", fwd_a); end
    n_cmp++; if (fwd_b !== 2'b00) begin n_err++; $display("FAIL fwd_b_none: got %b want 00", fwd_b); end
    mem_regwrite = 1'b0; #1;
    n_cmp++; if (fwd_a !== 2'b10) begin n_err++; $display("FAIL fwd_a_wb: got %b want 10", fwd_a); end
    wb_rd = 5'd0; #1;
    n_cmp++; if (fwd_a !== 2'b00) begin n_err++; $display("FAIL fwd_a_wb_rd0: got %b want 00", fwd_a); end
    ex_rs1 = 5'd0; ex_rs2 = 5'd9; mem_rd = 5'd9; mem_regwrite = 1'b1; wb_rd = 5'd9; #1;
    n_cmp++; if (fwd_b !== 2'b01 || z_fwd_b !== 2'b01) begin
      n_err++; $display("FAIL fwd_b_mem: got %b/%b want 01/01", fwd_b, z_fwd_b); end
    mem_rd = 5'd0; #1;
    n_cmp++; if (fwd_b !== 2'b10) begin n_err++; $display("FAIL fwd_b_wb: got %b want 10", fwd_b); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_wait();
    mem_access = 1'b1; #1;
    step();
    n_cmp++; if (ctl !== FRZV) begin n_err++; $display("FAIL midwait_pre: got %b want %b", ctl, FRZV); end
    #2 reset = 1'b1; #1;
    n_cmp++; if (ctl !== BOOTV || busy !== 1'b1) begin
      n_err++; $display("FAIL midwait_async_boot: got %b/%b want %b/1", ctl, busy, BOOTV); end
`ifdef PIPE_HAZARD_PERF_EN
    n_cmp++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      n_err++; $display("FAIL midwait_perf: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
`endif
    @(negedge clk); reset = 1'b0; mem_access = 1'b0;
    step();
    n_cmp++; if (ctl !== BOOTV) begin n_err++; $display("FAIL midwait_boot2: got %b want %b", ctl, BOOTV); end
    step();
    n_cmp++; if (ctl !== RUNV || busy !== 1'b0) begin
      n_err++; $display("FAIL midwait_run: got %b/%b want %b/0", ctl, busy, RUNV); end
  endtask

  initial begin
    test_reset();
    test_freeze();
    test_load_use();
    test_redirect();
    test_forward();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
